// File: rtl/dct8_lift_stream.sv
`default_nettype none
// ============================================================================
// dct8_lift_stream : 8-point multiplier-free lifting forward DCT, valid/ready
//                    stream with backpressure, 8 register stages.
// Revision 1.0
// ============================================================================
module dct8_lift_stream #(
    parameter int W_IN      = 8,
    parameter int SIGNED_IN = 0,
    parameter int W_OUT     = 16,
    parameter int FRAC      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lvl_shift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [8*W_IN-1:0]  x_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [8*W_OUT-1:0] x_out
);
    localparam int WI = W_OUT + FRAC;
    localparam int WR = WI + 2;
    localparam int NS = 8;

    localparam logic [WR-1:0]        C_HALF = WR'(1) << (FRAC - 1);
    localparam logic [WR-1:0]        C_KEEP = ~((WR'(1) << FRAC) - WR'(1));
    localparam logic signed [WI-1:0] C_LVL  = WI'(1) << (W_IN - 1);

    typedef logic signed [WI-1:0] lane_t;

    // Two guard bits so the sum of up to three shifted terms cannot wrap.
    function automatic logic signed [WR-1:0] sx(input lane_t v);
        return {{2{v[WI-1]}}, v};
    endfunction

    // Round to a multiple of 2^FRAC, ties away from zero (done on magnitude).
    function automatic lane_t rnd(input logic signed [WR-1:0] s);
        logic [WR-1:0] mag;
        logic [WR-1:0] rmag;
        mag  = s[WR-1] ? WR'(-s) : WR'(s);
        rmag = (mag + C_HALF) & C_KEEP;
        return s[WR-1] ? lane_t'(-rmag) : lane_t'(rmag);
    endfunction

    logic          w_en;
    logic [NS-1:0] r_v;
    logic [NS-1:0] r_last;

    lane_t w_conv [8];
    lane_t w_a    [8];
    lane_t w_p    [8];
    lane_t w_q    [8];
    lane_t w_b    [8];
    lane_t w_c    [8];
    lane_t w_y    [8];

    lane_t r_x [8];
    lane_t r_a [8];
    lane_t r_p [8];
    lane_t r_q [8];
    lane_t r_b [8];
    lane_t r_c [8];
    lane_t r_y [8];
    logic signed [W_OUT-1:0] r_out [8];

    assign w_en      = !(r_v[NS-1] && !out_ready);
    assign in_ready  = w_en;
    assign out_valid = r_v[NS-1];
    assign out_last  = r_last[NS-1];

    for (genvar i = 0; i < 8; i++) begin : g_conv
        logic [W_IN-1:0] w_raw;
        lane_t           w_ext;
        assign w_raw = x_in[i*W_IN +: W_IN];
        if (SIGNED_IN != 0) begin : g_sext
            assign w_ext = {{(WI-W_IN){w_raw[W_IN-1]}}, w_raw};
        end else begin : g_zext
            assign w_ext = {{(WI-W_IN){1'b0}}, w_raw} - (lvl_shift ? C_LVL : '0);
        end
        assign w_conv[i] = w_ext <<< FRAC;
    end

    if (SIGNED_IN != 0) begin : g_lvl_unused
        logic w_unused_lvl;
        assign w_unused_lvl = lvl_shift;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_a[i]   = r_x[i] + r_x[7-i];
            w_a[4+i] = r_x[3-i] - r_x[4+i];
        end

        w_p    = r_a;
        w_p[6] = r_a[6] + rnd((sx(r_a[5]) >>> 3) + (sx(r_a[5]) >>> 2));

        w_q    = r_p;
        w_q[5] = rnd((sx(r_p[6]) >>> 3) + (sx(r_p[6]) >>> 1)) - r_p[5];

        w_b[0] = r_q[0] + r_q[3];
        w_b[1] = r_q[1] + r_q[2];
        w_b[2] = r_q[1] - r_q[2];
        w_b[3] = r_q[0] - r_q[3];
        w_b[4] = r_q[4] + r_q[5];
        w_b[5] = r_q[4] - r_q[5];
        w_b[6] = r_q[7] - r_q[6];
        w_b[7] = r_q[7] + r_q[6];

        w_c    = r_b;
        w_c[0] = r_b[0] + r_b[1];
        w_c[2] = r_b[2] - rnd((sx(r_b[3]) >>> 3) + (sx(r_b[3]) >>> 2));
        w_c[5] = rnd((sx(r_b[6]) >>> 3) + (sx(r_b[6]) >>> 2) + (sx(r_b[6]) >>> 1)) + r_b[5];

        // Lanes 1,3,4,6,7 of r_c still carry the b values from the previous stage.
        w_y    = r_c;
        w_y[1] = rnd(sx(r_c[0]) >>> 1) - r_c[1];
        w_y[3] = rnd((sx(r_c[2]) >>> 3) + (sx(r_c[2]) >>> 2)) + r_c[3];
        w_y[4] = r_c[4] - rnd(sx(r_c[7]) >>> 3);
        w_y[6] = r_c[6] - rnd(sx(r_c[5]) >>> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_last <= '0;
            for (int i = 0; i < 8; i++) begin
                r_x[i]   <= '0;
                r_a[i]   <= '0;
                r_p[i]   <= '0;
                r_q[i]   <= '0;
                r_b[i]   <= '0;
                r_c[i]   <= '0;
                r_y[i]   <= '0;
                r_out[i] <= '0;
            end
        end else if (w_en) begin
            r_v    <= {r_v[NS-2:0], in_valid};
            r_last <= {r_last[NS-2:0], in_last & in_valid};
            // Data registers only move for real beats, so x_out keeps its last value across bubbles.
            if (in_valid) r_x <= w_conv;
            if (r_v[0])   r_a <= w_a;
            if (r_v[1])   r_p <= w_p;
            if (r_v[2])   r_q <= w_q;
            if (r_v[3])   r_b <= w_b;
            if (r_v[4])   r_c <= w_c;
            if (r_v[5])   r_y <= w_y;
            if (r_v[6]) begin
                for (int i = 0; i < 8; i++) begin
                    r_out[i] <= r_y[i][WI-1:FRAC];
                end
            end
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_out
        logic [FRAC-1:0] w_unused_frac;
        assign w_unused_frac            = r_y[k][FRAC-1:0];
        assign x_out[k*W_OUT +: W_OUT]  = r_out[k];
    end

endmodule
`default_nettype wire
